// File: rtl/lfsr16_checker.sv
// lfsr16_checker
//   Receive-side PRBS sink for the 16-bit Fibonacci LFSR stream of lfsr16.
//   Self-synchronises on the incoming words, declares lock after LOCK_COUNT
//   consecutive correct successors of a seed, counts mismatches while locked
//   and drops lock after LOSS_COUNT consecutive mismatches.
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   valid_i    data_i carries one generator step this cycle
//   data_i     received LFSR word
//   clear_i    synchronous clear of err_cnt_o (applied before a same-cycle increment)
//   locked_o   checker is locked to the stream
//   err_o      one-cycle pulse: previous accepted sample mismatched while locked
//   err_cnt_o  saturating count of locked-state mismatches
module lfsr16_checker #(
  parameter logic [15:0] TAPS       = 16'hD008,
  parameter int          LOCK_COUNT = 8,
  parameter int          LOSS_COUNT = 4,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [15:0]      data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [RUN_W-1:0]  LOCK_V = RUN_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] LOSS_V = MISS_W'(LOSS_COUNT);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & TAPS)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  state_t             state_p0, state_nxt;
  logic               have_seed_p0, have_seed_nxt;
  logic [15:0]        seed_p0, seed_nxt;
  logic [RUN_W-1:0]   run_p0, run_nxt, run_inc;
  logic [MISS_W-1:0]  miss_p0, miss_nxt, miss_inc;
  logic [15:0]        exp_p0, exp_nxt;
  logic               err_p0, err_nxt;
  logic [CNT_W-1:0]   cnt_p0, cnt_nxt;

  assign run_inc  = run_p0 + 1'b1;
  assign miss_inc = miss_p0 + 1'b1;

  // ---- stage p0: state register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p0     <= SEARCH;
      have_seed_p0 <= 1'b0;
      seed_p0      <= '0;
      run_p0       <= '0;
      miss_p0      <= '0;
      exp_p0       <= '0;
      err_p0       <= 1'b0;
      cnt_p0       <= '0;
    end else begin
      state_p0     <= state_nxt;
      have_seed_p0 <= have_seed_nxt;
      seed_p0      <= seed_nxt;
      run_p0       <= run_nxt;
      miss_p0      <= miss_nxt;
      exp_p0       <= exp_nxt;
      err_p0       <= err_nxt;
      cnt_p0       <= cnt_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt     = state_p0;
    have_seed_nxt = have_seed_p0;
    seed_nxt      = seed_p0;
    run_nxt       = run_p0;
    miss_nxt      = miss_p0;
    exp_nxt       = exp_p0;
    err_nxt       = 1'b0;
    // Clear takes effect first so a same-cycle mismatch leaves a count of 1.
    cnt_nxt       = clear_i ? '0 : cnt_p0;

    if (valid_i) begin
      case (state_p0)
        SEARCH: begin
          if (!have_seed_p0) begin
            // All-zero is the LFSR lock-up word and can never seed.
            if (data_i != '0) begin
              seed_nxt      = data_i;
              have_seed_nxt = 1'b1;
              run_nxt       = '0;
            end
          end else if (data_i == lfsr_next(seed_p0)) begin
            seed_nxt = data_i;
            run_nxt  = run_inc;
            if (run_inc == LOCK_V) begin
              state_nxt = LOCKED;
              exp_nxt   = lfsr_next(data_i);
              miss_nxt  = '0;
              run_nxt   = '0;
            end
          end else begin
            run_nxt = '0;
            if (data_i != '0) seed_nxt = data_i;
            else              have_seed_nxt = 1'b0;
          end
        end
        LOCKED: begin
          // Prediction free-runs; a single corrupted word costs one error.
          exp_nxt = lfsr_next(exp_p0);
          if (data_i == exp_p0) begin
            miss_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            cnt_nxt = sat_inc(cnt_nxt);
            if (miss_inc == LOSS_V) begin
              state_nxt     = SEARCH;
              have_seed_nxt = 1'b0;
              run_nxt       = '0;
              miss_nxt      = '0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // ---- outputs ----
  always_comb begin
    locked_o  = (state_p0 == LOCKED);
    err_o     = err_p0;
    err_cnt_o = cnt_p0;
  end

endmodule

// File: tb/tb_lfsr16_checker.sv
module tb_lfsr16_checker;

  localparam logic [15:0] TAPS = 16'hD008;
  localparam int LOCK = 8;
  localparam int LOSS = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        clear_i = 1'b0;
  logic        locked, err, locked4, err4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  lfsr16_checker u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(locked), .err_o(err), .err_cnt_o(cnt)
  );

  lfsr16_checker #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .clear_i(clear_i), .locked_o(locked4), .err_o(err4), .err_cnt_o(cnt4)
  );

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic        m_locked, m_have, m_err;
  logic [15:0] m_seed, m_exp;
  int          m_run, m_miss, m_cnt16, m_cnt4;
  logic [15:0] g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], ^(x & TAPS)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_err = 0; m_seed = '0; m_exp = '0;
    m_run = 0; m_miss = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    valid_i = v; data_i = d; clear_i = c;
    m_err = 0;
    if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    if (v) begin
      if (!m_locked) begin
        if (!m_have) begin
          if (d != 0) begin m_seed = d; m_have = 1; m_run = 0; end
        end else if (d == nxt(m_seed)) begin
          m_seed = d;
          m_run++;
          if (m_run == LOCK) begin
            m_locked = 1; m_exp = nxt(d); m_miss = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
          if (d != 0) m_seed = d; else m_have = 0;
        end
      end else begin
        if (d != m_exp) begin
          m_err = 1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 0; m_have = 0; m_run = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    e.locked = m_locked; e.err = m_err; e.cnt = 16'(m_cnt16); e.cnt4 = 4'(m_cnt4);
    sb.push_back(e);
  endtask

  // Scoreboard consumer: one expected entry per driven cycle.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("locked", 32'(locked), 32'(mon_e.locked));
      check("err", 32'(err), 32'(mon_e.err));
      check("err_cnt", 32'(cnt), 32'(mon_e.cnt));
      check("locked_w4", 32'(locked4), 32'(mon_e.locked));
      check("err_cnt_w4", 32'(cnt4), 32'(mon_e.cnt4));
    end
  end

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, g, 1'b0);
      g = nxt(g);
    end
  endtask

  task automatic send_bad(input logic [15:0] flip);
    step(1'b1, g ^ flip, 1'b0);
    g = nxt(g);
  endtask

  // Idle cycle, then read outputs directly after the following edge.
  task automatic peek(input string tag, input logic exp_lock, input logic [15:0] exp_cnt,
                      input logic [3:0] exp_cnt4);
    step(1'b0, 16'h0, 1'b0);
    @(posedge clk);
    #2;
    check({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    check({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    check({tag, "_cnt4"}, 32'(cnt4), 32'(exp_cnt4));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = '0;
    model_reset();
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_cnt4", 32'(cnt4), 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();

    // Lock on the reference sequence
    do_reset();
    g = 16'h0001;
    send_good(8);
    peek("t1_pre", 1'b0, 16'd0, 4'd0);
    send_good(1);
    peek("t1_lock", 1'b1, 16'd0, 4'd0);

    // Single isolated error
    send_good(3);
    send_bad(16'h0001);
    send_good(5);
    peek("t2", 1'b1, 16'd1, 4'd1);

    // Loss of lock and relock
    do_reset();
    g = 16'h0001;
    send_good(9);
    for (int i = 0; i < 3; i++) send_bad(16'h8000);
    peek("t3_3bad", 1'b1, 16'd3, 4'd3);
    send_bad(16'h8000);
    peek("t3_lost", 1'b0, 16'd4, 4'd4);
    send_good(8);
    peek("t3_pre", 1'b0, 16'd4, 4'd4);
    send_good(1);
    peek("t3_relock", 1'b1, 16'd4, 4'd4);

    // Gaps between samples, then all-zero stream
    do_reset();
    g = 16'h0001;
    for (int i = 0; i < 9; i++) begin
      send_good(1);
      repeat ($urandom_range(0, 3)) step(1'b0, 16'(32'($urandom)), 1'b0);
    end
    peek("t4_gap", 1'b1, 16'd0, 4'd0);
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 16'h0000, 1'b0);
    peek("t4_zero", 1'b0, 16'd0, 4'd0);

    // Saturation and clear
    do_reset();
    g = 16'h0001;
    send_good(9);
    for (int i = 0; i < 20; i++) begin
      send_bad(16'h0100);
      send_good(1);
    end
    peek("t5_sat", 1'b1, 16'd20, 4'd15);
    step(1'b1, g ^ 16'h0004, 1'b1);
    g = nxt(g);
    peek("t5_clr", 1'b1, 16'd1, 4'd1);
    step(1'b1, g, 1'b1);
    g = nxt(g);
    peek("t5_clr0", 1'b1, 16'd0, 4'd0);

    // Asynchronous reset while locked, err_o high
    do_reset();
    g = 16'h0001;
    send_good(9);
    send_bad(16'h0002); send_good(1);
    send_bad(16'h0002); send_good(1);
    send_bad(16'h0002);
    @(posedge clk);
    #2;
    check("t6_err_before", 32'(err), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_err", 32'(err), 32'd0);
    check("t6_async_cnt", 32'(cnt), 32'd0);
    model_reset();
    @(negedge clk);
    valid_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    send_good(8);
    peek("t6_pre", 1'b0, 16'd0, 4'd0);
    send_good(1);
    peek("t6_relock", 1'b1, 16'd0, 4'd0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lfsr16_checker.md
Name: lfsr16_checker

Overview:
- Receive-side checker for the 16-bit Fibonacci LFSR stream produced by the team's lfsr16 generator, using the same recurrence with taps 0xD008.
- Each valid input word is one generator step.
- The block self-synchronises to the incoming stream, declares lock, counts bit-pattern mismatches and drops lock on sustained errors.
- It sits at the far end of a link or memory path under test, as the PRBS sink for BIST.

Parameters:
TAPS, 16'hD008, feedback tap mask; must match the generator
LOCK_COUNT, 8, consecutive correct successors (after a seed) needed to declare lock; ≥1
LOSS_COUNT, 4, consecutive mismatches while locked that force loss of lock; ≥1
CNT_W, 16, width of the saturating error counter

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
valid_i  input  1  data_i carries a sample this cycle
data_i  input  16  received LFSR word
clear_i  input  1  synchronous clear of err_cnt_o
locked_o  output  1  checker is locked to the stream
err_o  output  1  one-cycle pulse: previous accepted sample mismatched while locked
err_cnt_o  output  CNT_W  saturating count of locked-state mismatches

Behaviour:
- Successor function: next(x) = {x[14:0], ^(x & TAPS)}.
- Outputs are registered. The result for the sample accepted at edge N appears after edge N.
- Reset (rst_ni low, asynchronous):
  - state=SEARCH, have_seed=0, run=0, miss_run=0, expected=0.
  - locked_o=0, err_o=0, err_cnt_o=0.
  - Reset mid-lock discards all state immediately.
- valid_i low: no state change; err_o=0 on the next cycle.
- SEARCH state (locked_o=0; errors are never counted):
  - have_seed=0 and data_i≠0: seed←data_i, have_seed←1, run←0.
  - have_seed=0 and data_i==0: ignore the sample. All-zero is the LFSR lock-up word and never seeds.
  - have_seed=1 and data_i==next(seed): seed←data_i, run←run+1.
    - If run+1==LOCK_COUNT: state←LOCKED, expected←next(data_i), miss_run←0, locked_o←1.
  - have_seed=1 and data_i≠next(seed): run←0.
    - If data_i≠0, reseed (seed←data_i); otherwise have_seed←0.
- LOCKED state (locked_o=1):
  - Every accepted sample: compare data_i with expected, then expected←next(expected) unconditionally. The prediction free-runs and is never resynchronised from received data, so an isolated corrupted word costs exactly one error.
  - Match: miss_run←0.
  - Mismatch: err_o pulses 1 for one cycle, err_cnt_o increments (saturating at 2^CNT_W−1), miss_run←miss_run+1.
    - If miss_run+1==LOSS_COUNT: state←SEARCH, have_seed←0, run←0, locked_o←0 on that same edge.
    - The sample causing loss of lock is not used as a seed.
- clear_i:
  - Sets err_cnt_o←0.
  - If a mismatch is counted in the same cycle, the result is 1 (clear first, then increment).
  - Does not affect lock state or err_o.
- Counters:
  - run needs ceil(log2(LOCK_COUNT+1)) bits; miss_run needs ceil(log2(LOSS_COUNT+1)) bits.
  - Neither wraps, because each is reset on reaching its threshold.
- Minimum lock latency: LOCK_COUNT+1 valid samples (1 seed + LOCK_COUNT successors).

Test Plan:
1. Lock: after reset, feed 0x0001,0x0002,0x0004,0x0008,0x0011,0x0022,0x0044,0x0088,0x0111 back-to-back -> locked_o=0 through the 8th sample, 1 after the 9th edge; err_o never pulses; err_cnt_o=0.
2. Single error: while locked, replace one word with word^0x0001, then continue the true sequence -> err_o pulses once, err_cnt_o=1, locked_o stays 1, subsequent words match with no further pulses.
3. Loss and relock: while locked, feed 4 consecutive corrupted words -> 4 err_o pulses, err_cnt_o=4, locked_o falls after the 4th. Then resume the correct stream -> relock after 9 valid samples; err_cnt_o still 4.
4. Gaps and zeros: the test-1 sequence with valid_i low on random cycles between samples -> identical lock point in sample count. Separately, a stream of 0x0000 words -> never locks, err_cnt_o=0.
5. Counter edges (CNT_W=4): force 20 isolated locked mismatches -> err_cnt_o saturates at 15. Assert clear_i in the same cycle as a mismatch -> err_cnt_o=1.
6. Async reset: drop rst_ni mid-cycle while locked with err_cnt_o=3 -> locked_o, err_o, err_cnt_o read 0 before the next clock edge; relock requires a full seed + LOCK_COUNT matches.
